ir_dispatch_queue: RTL and testbench
====================================

// Module: ir_dispatch_queue
// PURPOSE
//  Registered, parametrised successor to the combinational IR-to-microstate encoder.
//  - Accepts fetched 32-bit instructions over a valid/ready handshake.
//  - Evaluates the condition field against NZCV, maps each instruction to its control-unit
//    entry state, counts the LDM/STM register list, and buffers the results in a DEPTH-entry FIFO.
//  - Sits between the fetch stage and the microprogrammed control unit.
// PARAMETERS
//  STATE_W   8  width of the entry-state code; must be >= 6
//  DEPTH     2  FIFO entries; power of two, >= 2
//  NOP_CODE  1  state code issued for a condition-failed instruction
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  flush        in   1        synchronous queue clear (branch taken / exception)
//  in_valid     in   1        in_ir is valid
//  in_ready     out  1        queue can accept (= !full)
//  in_ir        in   32       instruction word
//  in_nzcv      in   4        flags {N,Z,C,V}, sampled on push
//  out_valid    out  1        head entry is valid
//  out_ready    in   1        control unit consumes the head
//  out_state    out  STATE_W  entry-state code of the head
//  out_ir       out  32       instruction word of the head
//  out_regcnt   out  5        popcount(IR[15:0]) for LDM/STM, else 0
//  out_condfail out  1        head failed its condition check
//  level        out  clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0): pointers=0, level=0, out_valid=0, in_ready=1.
//  - All head outputs read 0 whenever out_valid=0, in reset and out of reset.
//  Push = in_valid & in_ready; pop = out_valid & out_ready. Both act on the rising edge.
//  Latency: an entry pushed into an empty queue shows out_valid=1 the next cycle. No bypass.
//  Push and pop in the same cycle: level is unchanged.
//  - When full, in_ready=0, so no push is taken even while popping.
//  Flush: level=0 and pointers reset next edge; it overrides any push or pop in that cycle.
//  Pointers wrap modulo DEPTH. in_ready and out_valid are derived from registered level only.
//  Encode at push time (first match wins), codes decimal:
//   IR==0 -> 0, condfail=0 (cond check bypassed)
//   cond check fails -> NOP_CODE, condfail=1, regcnt=0
//   IR[27:24]=1111 (SWI) -> 60
//   IR[27:25]=011 & IR[4]=1 (undefined) -> 61
//   IR[27:25]=000 & IR[4]=0 -> 10
//   IR[27:25]=001 -> 11
//   IR[27:25]=010: P=0 -> 17; W=0 -> 16; else 19
//   IR[27:25]=011: P=0 -> 22; W=0 -> 21; else 23
//   IR[27:25]=000, IR[4]=1, IR[22]=1: P=0 -> 46; W=0 -> 47; else 48
//   IR[27:25]=000, IR[4]=1, IR[22]=0: P=0 -> 49; W=0 -> 50; else 51
//   IR[27:25]=100: P=0 -> 30, else 31; regcnt = popcount(IR[15:0]) (0..16)
//   all others: IR[24]=0 -> 45 (B), else 44 (BL)
//   (P = IR[24], W = IR[21])
//  Condition IR[31:28]:
//   EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
//   HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
//   AL pass; 1111 always fails
//  Flags used are in_nzcv at the push edge; later flag changes do not affect queued entries.
//  Codes are zero-extended to STATE_W.
// TESTING
//  1. Reset then idle -> in_ready=1, out_valid=0, out_state=0, level=0.
//  2. Push E3A01005 (MOV imm, AL), out_ready=1
//     -> next cycle out_valid=1, out_state=11, condfail=0; popped the cycle after.
//  3. Push 0A000003 (BEQ) with nzcv=0000 -> out_state=NOP_CODE, condfail=1;
//     with nzcv=0100 -> out_state=45.
//  4. Push E92D400F (STMDB, P=1) -> out_state=31, out_regcnt=5;
//     E8BD0000 (P=0, empty list) -> out_state=30, out_regcnt=0.
//  5. out_ready=0, push DEPTH entries -> in_ready=0, level=DEPTH, further pushes ignored;
//     then push+pop same cycle -> level constant, order preserved across pointer wrap.
//  6. Flush with level=2 and in_valid=1 -> level=0, out_valid=0 next cycle, pushed word dropped;
//     rst_n low mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/ir_dispatch_queue.sv
// Instruction dispatch queue: decodes fetched IR words into control-unit entry states
// at push time and buffers them in a DEPTH-entry FIFO ahead of the control unit.
module ir_dispatch_queue #(
   parameter int STATE_W  = 8,
   parameter int DEPTH    = 2,
   parameter int NOP_CODE = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_ir,
   input  logic [3:0]                 in_nzcv,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [STATE_W-1:0]         out_state,
   output logic [31:0]                out_ir,
   output logic [4:0]                 out_regcnt,
   output logic                       out_condfail,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   // Handshake: a push happens on a rising edge where in_valid & in_ready, a pop where
   // out_valid & out_ready; both flags come from the registered level only.
   logic          push;
   logic          pop;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic [STATE_W-1:0] state_mem [DEPTH];
   logic [31:0]        ir_mem    [DEPTH];
   logic [4:0]         cnt_mem   [DEPTH];
   logic               cf_mem    [DEPTH];

   logic [STATE_W-1:0] enc_state;
   logic [4:0]         enc_cnt;
   logic               enc_cf;
   logic               cond_pass;

   assign in_ready  = (level != LW'(DEPTH));
   assign out_valid = (level != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] acc;
      acc = '0;
      for (int i = 0; i < 16; i++) acc = acc + 5'(v[i]);
      return acc;
   endfunction

   always_comb begin
      logic n, z, c, v;
      {n, z, c, v} = in_nzcv;
      cond_pass = 1'b0;
      case (in_ir[31:28])
         4'h0: cond_pass = z;
         4'h1: cond_pass = !z;
         4'h2: cond_pass = c;
         4'h3: cond_pass = !c;
         4'h4: cond_pass = n;
         4'h5: cond_pass = !n;
         4'h6: cond_pass = v;
         4'h7: cond_pass = !v;
         4'h8: cond_pass = c & !z;
         4'h9: cond_pass = !c | z;
         4'hA: cond_pass = (n == v);
         4'hB: cond_pass = (n != v);
         4'hC: cond_pass = !z & (n == v);
         4'hD: cond_pass = z | (n != v);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Priority decode; the all-zero word skips the condition check entirely.
   always_comb begin
      logic [2:0] op;
      logic       p, w, b4;
      op        = in_ir[27:25];
      p         = in_ir[24];
      w         = in_ir[21];
      b4        = in_ir[4];
      enc_state = '0;
      enc_cnt   = '0;
      enc_cf    = 1'b0;
      if (in_ir == 32'h0) begin
         enc_state = '0;
      end else if (!cond_pass) begin
         enc_state = STATE_W'(NOP_CODE);
         enc_cf    = 1'b1;
      end else if (in_ir[27:24] == 4'hF) begin
         enc_state = STATE_W'(60);
      end else if (op == 3'b011 && b4) begin
         enc_state = STATE_W'(61);
      end else if (op == 3'b000 && !b4) begin
         enc_state = STATE_W'(10);
      end else if (op == 3'b001) begin
         enc_state = STATE_W'(11);
      end else if (op == 3'b010) begin
         enc_state = !p ? STATE_W'(17) : (!w ? STATE_W'(16) : STATE_W'(19));
      end else if (op == 3'b011) begin
         enc_state = !p ? STATE_W'(22) : (!w ? STATE_W'(21) : STATE_W'(23));
      end else if (op == 3'b000 && in_ir[22]) begin
         enc_state = !p ? STATE_W'(46) : (!w ? STATE_W'(47) : STATE_W'(48));
      end else if (op == 3'b000) begin
         enc_state = !p ? STATE_W'(49) : (!w ? STATE_W'(50) : STATE_W'(51));
      end else if (op == 3'b100) begin
         enc_state = !p ? STATE_W'(30) : STATE_W'(31);
         enc_cnt   = popcount16(in_ir[15:0]);
      end else begin
         enc_state = !p ? STATE_W'(45) : STATE_W'(44);
      end
   end

   // Storage is not reset: head outputs are gated by out_valid instead.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         state_mem[wr_ptr] <= enc_state;
         ir_mem[wr_ptr]    <= in_ir;
         cnt_mem[wr_ptr]   <= enc_cnt;
         cf_mem[wr_ptr]    <= enc_cf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign out_state    = out_valid ? state_mem[rd_ptr] : '0;
   assign out_ir       = out_valid ? ir_mem[rd_ptr]    : '0;
   assign out_regcnt   = out_valid ? cnt_mem[rd_ptr]   : '0;
   assign out_condfail = out_valid ? cf_mem[rd_ptr]    : 1'b0;

endmodule

// File: tb/tb_ir_dispatch_queue.sv
// Bench for ir_dispatch_queue: scenario tasks plus a negedge scoreboard fed by a
// reference decode model.
module tb_ir_dispatch_queue;

   localparam int STATE_W = 8;
   localparam int DEPTH   = 2;
   localparam int NOP     = 1;
   localparam int EW      = STATE_W + 32 + 5 + 1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               flush = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [31:0]        in_ir = '0;
   logic [3:0]         in_nzcv = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [STATE_W-1:0] out_state;
   logic [31:0]        out_ir;
   logic [4:0]         out_regcnt;
   logic               out_condfail;
   logic [$clog2(DEPTH):0] level;

   int checks = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];

   ir_dispatch_queue #(.STATE_W(STATE_W), .DEPTH(DEPTH), .NOP_CODE(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_nzcv(in_nzcv),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
      .out_ir(out_ir), .out_regcnt(out_regcnt), .out_condfail(out_condfail),
      .level(level)
   );

   always #5 clk = ~clk;

   function automatic logic [EW-1:0] model(input logic [31:0] ir, input logic [3:0] f);
      logic n, z, c, v, pass, p, w;
      logic [7:0] st;
      logic [4:0] cnt;
      logic cf;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      p = ir[24]; w = ir[21];
      st = 8'd0; cnt = 5'd0; cf = 1'b0;
      case (ir[31:28])
         0: pass = z;            1: pass = !z;
         2: pass = c;            3: pass = !c;
         4: pass = n;            5: pass = !n;
         6: pass = v;            7: pass = !v;
         8: pass = c && !z;      9: pass = !c || z;
         10: pass = (n == v);    11: pass = (n != v);
         12: pass = !z && (n == v);
         13: pass = z || (n != v);
         14: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      if (ir == 32'd0) st = 8'd0;
      else if (!pass) begin st = 8'(NOP); cf = 1'b1; end
      else if (ir[27:24] == 4'b1111) st = 8'd60;
      else if (ir[27:25] == 3'b011 && ir[4]) st = 8'd61;
      else if (ir[27:25] == 3'b000 && !ir[4]) st = 8'd10;
      else if (ir[27:25] == 3'b001) st = 8'd11;
      else if (ir[27:25] == 3'b010) st = (p == 0) ? 8'd17 : (w == 0) ? 8'd16 : 8'd19;
      else if (ir[27:25] == 3'b011) st = (p == 0) ? 8'd22 : (w == 0) ? 8'd21 : 8'd23;
      else if (ir[27:25] == 3'b000 && ir[22]) st = (p == 0) ? 8'd46 : (w == 0) ? 8'd47 : 8'd48;
      else if (ir[27:25] == 3'b000) st = (p == 0) ? 8'd49 : (w == 0) ? 8'd50 : 8'd51;
      else if (ir[27:25] == 3'b100) begin
         st = (p == 0) ? 8'd30 : 8'd31;
         cnt = 5'($countones(ir[15:0]));
      end else st = (p == 0) ? 8'd45 : 8'd44;
      return {st, ir, cnt, cf};
   endfunction

   // Scoreboard: samples at negedge when inputs and outputs are stable.
   always @(negedge clk) begin
      logic [EW-1:0] obs, exp;
      if (!rst_n || flush) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            obs = {out_state, out_ir, out_regcnt, out_condfail};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected got=%h expected=none", obs);
            end else begin
               exp = exp_q.pop_front();
               if (obs !== exp) begin
                  failures++;
                  $display("FAIL sb_entry got=%h expected=%h", obs, exp);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_ir, in_nzcv));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] ir, input logic [3:0] f);
      int t;
      in_ir = ir; in_nzcv = f; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin step(); t++; end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL push_timeout in_ready=%b required=1", in_ready);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({in_ready, out_valid, out_state, out_ir, level} !== {1'b1, 1'b0, 8'd0, 32'd0, 2'd0}) begin
         failures++;
         $display("FAIL reset_in rdy=%b vld=%b st=%0d ir=%h lvl=%0d required 1 0 0 0 0",
                  in_ready, out_valid, out_state, out_ir, level);
      end
      step();
      rst_n = 1'b1;
      step(); step();
      checks++;
      if ({in_ready, out_valid, out_state, out_regcnt, out_condfail, level} !== {1'b1, 1'b0, 8'd0, 5'd0, 1'b0, 2'd0}) begin
         failures++;
         $display("FAIL reset_idle rdy=%b vld=%b st=%0d lvl=%0d required 1 0 0 0",
                  in_ready, out_valid, out_state, level);
      end
   endtask

   task automatic test_mov();
      out_ready = 1'b1;
      in_ir = 32'hE3A01005; in_nzcv = 4'h0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_state, out_condfail} !== {1'b1, 8'd11, 1'b0}) begin
         failures++;
         $display("FAIL mov_head vld=%b st=%0d cf=%b required 1 11 0", out_valid, out_state, out_condfail);
      end
      step();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, out_state, level} !== {1'b0, 8'd0, 2'd0}) begin
         failures++;
         $display("FAIL mov_popped vld=%b st=%0d lvl=%0d required 0 0 0", out_valid, out_state, level);
      end
   endtask

   task automatic test_cond();
      push_one(32'h0A000003, 4'b0000);
      checks++;
      if ({out_state, out_condfail, out_regcnt} !== {8'(NOP), 1'b1, 5'd0}) begin
         failures++;
         $display("FAIL beq_fail st=%0d cf=%b cnt=%0d required %0d 1 0", out_state, out_condfail, out_regcnt, NOP);
      end
      pop_one();
      push_one(32'h0A000003, 4'b0100);
      // Flags changing after the push must not alter the queued entry.
      in_nzcv = 4'b0000;
      step();
      checks++;
      if ({out_state, out_condfail} !== {8'd45, 1'b0}) begin
         failures++;
         $display("FAIL beq_pass st=%0d cf=%b required 45 0", out_state, out_condfail);
      end
      pop_one();
   endtask

   task automatic test_ldm_stm();
      push_one(32'hE92D400F, 4'h0);
      checks++;
      if ({out_state, out_regcnt} !== {8'd31, 5'd5}) begin
         failures++;
         $display("FAIL stmdb st=%0d cnt=%0d required 31 5", out_state, out_regcnt);
      end
      pop_one();
      push_one(32'hE8BD0000, 4'h0);
      checks++;
      if ({out_state, out_regcnt} !== {8'd30, 5'd0}) begin
         failures++;
         $display("FAIL ldm_empty st=%0d cnt=%0d required 30 0", out_state, out_regcnt);
      end
      pop_one();
      push_one(32'hE8BDFFFF, 4'h0);
      checks++;
      if ({out_state, out_regcnt} !== {8'd30, 5'd16}) begin
         failures++;
         $display("FAIL ldm_full st=%0d cnt=%0d required 30 16", out_state, out_regcnt);
      end
      pop_one();
   endtask

   task automatic test_full_wrap();
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) push_one(32'hE3A00000 + 32'(i), 4'h0);
      checks++;
      if ({in_ready, level} !== {1'b0, 2'(DEPTH)}) begin
         failures++;
         $display("FAIL full rdy=%b lvl=%0d required 0 %0d", in_ready, level, DEPTH);
      end
      in_ir = 32'hE1A00000; in_valid = 1'b1;
      step(); step();
      checks++;
      if ({level, out_ir} !== {2'(DEPTH), 32'hE3A00000}) begin
         failures++;
         $display("FAIL full_ignore lvl=%0d ir=%h required %0d E3A00000", level, out_ir, DEPTH);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (level !== 2'(DEPTH - 1)) begin
         failures++;
         $display("FAIL full_pop_no_push lvl=%0d required %0d", level, DEPTH - 1);
      end
      for (int i = 0; i < 6; i++) begin
         in_ir = 32'hE2800000 + 32'(i);
         step();
         checks++;
         if (level !== 2'(DEPTH - 1)) begin
            failures++;
            $display("FAIL push_pop_level lvl=%0d required %0d", level, DEPTH - 1);
         end
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 2; i++) push_one(32'hE5900000 + 32'(i), 4'h0);
      flush = 1'b1; in_valid = 1'b1; in_ir = 32'hE3A0F000; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if ({level, out_valid, out_state, out_ir} !== {2'd0, 1'b0, 8'd0, 32'd0}) begin
         failures++;
         $display("FAIL flush_full lvl=%0d vld=%b st=%0d required 0 0 0", level, out_valid, out_state);
      end
      push_one(32'hE5900004, 4'h0);
      flush = 1'b1; in_valid = 1'b1; in_ir = 32'hE3A0F001;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if ({level, out_valid, in_ready} !== {2'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL flush_push lvl=%0d vld=%b rdy=%b required 0 0 1", level, out_valid, in_ready);
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      for (int i = 0; i < 400; i++) begin
         r = $urandom;
         if ($urandom_range(0, 2) == 0) r[31:28] = 4'hE;
         if ($urandom_range(0, 15) == 0) r = 32'd0;
         in_ir = r;
         in_nzcv = 4'($urandom_range(0, 15));
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 49) == 0);
         step();
         checks++;
         if (int'(level) !== exp_q.size()) begin
            failures++;
            $display("FAIL rand_level lvl=%0d required %0d", level, exp_q.size());
         end
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 20 && out_valid; t++) step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL rand_drain vld=%b pending=%0d required 0 0", out_valid, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      push_one(32'hEF000011, 4'h0);
      checks++;
      if (out_state !== 8'd60) begin
         failures++;
         $display("FAIL swi st=%0d required 60", out_state);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_state, out_ir, level, in_ready} !== {1'b0, 8'd0, 32'd0, 2'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset_mid vld=%b st=%0d ir=%h lvl=%0d required 0 0 0 0", out_valid, out_state, out_ir, level);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_mov();
      test_cond();
      test_ldm_stm();
      test_full_wrap();
      test_flush();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
